// File: rtl/request_queue.sv
// Time-gated single-entry stage feeding a DEPTH-entry in-order request queue with per-entry age.
// Accept-to-head latency >= 1 cycle; in_ready drops while a request is staged, head holds until out_ready.
module request_queue #(
  parameter int ADDRESS_WIDTH = 33,
  parameter int DEPTH         = 16,
  parameter int LIFE_W        = 8,
  parameter int FAST_FWD      = 1
) (
  input  logic                     CPU_clock,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [31:0]              in_time,
  input  logic [1:0]               in_op,
  input  logic [ADDRESS_WIDTH-1:0] in_addr,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [1:0]               out_op,
  output logic [ADDRESS_WIDTH-1:0] out_addr,
  output logic [LIFE_W-1:0]        out_life,
  input  logic                     out_ready,
  output logic [31:0]              cycle_count,
  output logic                     q_full,
  output logic                     q_empty,
  output logic [$clog2(DEPTH):0]   occupancy
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [1:0]        OP_NOP   = 2'd3;
  localparam logic [OCC_W-1:0]  OCC_FULL = OCC_W'(DEPTH);
  localparam logic [LIFE_W-1:0] LIFE_MAX = '1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("request_queue: DEPTH must be a power of 2 and at least 2");
  end

  typedef struct packed {
    logic [1:0]               op;
    logic [ADDRESS_WIDTH-1:0] addr;
  } req_t;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_TIME  = 2'd1,
    WAIT_SPACE = 2'd2
  } stage_state_t;

  stage_state_t state, state_nxt;
  req_t         stg_req;
  logic [31:0]  stg_time;

  req_t              ent_req  [DEPTH];
  logic [LIFE_W-1:0] ent_life [DEPTH];
  logic [DEPTH-1:0]  ent_vld;
  logic [PTR_W-1:0]  head, tail;

  logic             stage_load, enq, pop, time_reached;
  logic [31:0]      cc_inc, cc_nxt;
  logic [OCC_W-1:0] occ_nxt;

  assign time_reached = cycle_count >= stg_time;
  assign out_valid    = !q_empty;
  assign pop          = out_valid && out_ready;
  assign out_op       = ent_req[head].op;
  assign out_addr     = ent_req[head].addr;
  assign out_life     = ent_life[head];
  assign cc_inc       = cycle_count + 32'd1;

  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    stage_load = 1'b0;
    enq        = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid && in_op != OP_NOP) begin
          stage_load = 1'b1;
          state_nxt  = (in_time <= cycle_count) ? WAIT_SPACE : WAIT_TIME;
        end
      end
      WAIT_TIME: begin
        if (time_reached) begin
          if (!q_full) begin
            enq       = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = WAIT_SPACE;
          end
        end
      end
      WAIT_SPACE: begin
        // A pop frees the head slot in the same edge, so full+pop still admits the stage.
        if (!q_full || pop) begin
          enq       = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cc_nxt = cc_inc;
    if (FAST_FWD != 0 && q_empty && state == WAIT_TIME && stg_time > cc_inc) begin
      cc_nxt = stg_time;
    end
  end

  always_comb begin
    occ_nxt = occupancy;
    case ({enq, pop})
      2'b10:   occ_nxt = occupancy + OCC_W'(1);
      2'b01:   occ_nxt = occupancy - OCC_W'(1);
      default: occ_nxt = occupancy;
    endcase
  end

  always_ff @(posedge CPU_clock) begin
    if (!rst_n) begin
      state       <= IDLE;
      stg_req     <= '0;
      stg_time    <= '0;
      cycle_count <= '0;
    end else begin
      state       <= state_nxt;
      cycle_count <= cc_nxt;
      if (stage_load) begin
        stg_req  <= '{op: in_op, addr: in_addr};
        stg_time <= in_time;
      end
    end
  end

  always_ff @(posedge CPU_clock) begin
    if (!rst_n) begin
      head      <= '0;
      tail      <= '0;
      occupancy <= '0;
      q_full    <= 1'b0;
      q_empty   <= 1'b1;
      ent_vld   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_req[i]  <= '0;
        ent_life[i] <= '0;
      end
    end else begin
      occupancy <= occ_nxt;
      q_full    <= occ_nxt == OCC_FULL;
      q_empty   <= occ_nxt == '0;
      if (pop) head <= head + PTR_W'(1);
      if (enq) tail <= tail + PTR_W'(1);
      // Enqueue wins over pop on the same slot (full queue, head == tail).
      for (int i = 0; i < DEPTH; i++) begin
        if (enq && tail == PTR_W'(i)) begin
          ent_req[i]  <= stg_req;
          ent_life[i] <= '0;
          ent_vld[i]  <= 1'b1;
        end else begin
          if (pop && head == PTR_W'(i)) ent_vld[i] <= 1'b0;
          if (ent_vld[i] && ent_life[i] != LIFE_MAX) ent_life[i] <= ent_life[i] + LIFE_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_request_queue.sv
// Bench for request_queue: directed vector table, hand sequences and a randomized run against a queue-level model.
module tb_request_queue;
  localparam int AW       = 33;
  localparam int DEPTH    = 16;
  localparam int LIFE_W   = 8;
  localparam int OCC_W    = 5;
  localparam int LIFE_MAX = 255;

  logic CPU_clock = 1'b0;
  always #5 CPU_clock = ~CPU_clock;

  logic              rst_n, in_valid, in_ready, out_valid, out_ready, q_full, q_empty;
  logic [31:0]       in_time, cycle_count;
  logic [1:0]        in_op, out_op;
  logic [AW-1:0]     in_addr, out_addr;
  logic [LIFE_W-1:0] out_life;
  logic [OCC_W-1:0]  occupancy;

  logic              f_rst_n, f_in_valid, f_in_ready, f_out_valid, f_out_ready, f_q_full, f_q_empty;
  logic [31:0]       f_in_time, f_cc;
  logic [1:0]        f_in_op, f_out_op;
  logic [AW-1:0]     f_in_addr, f_out_addr;
  logic [LIFE_W-1:0] f_out_life;
  logic [OCC_W-1:0]  f_occ;

  request_queue #(.ADDRESS_WIDTH(AW), .DEPTH(DEPTH), .LIFE_W(LIFE_W), .FAST_FWD(0)) dut (
    .CPU_clock(CPU_clock), .rst_n(rst_n), .in_valid(in_valid), .in_time(in_time),
    .in_op(in_op), .in_addr(in_addr), .in_ready(in_ready), .out_valid(out_valid),
    .out_op(out_op), .out_addr(out_addr), .out_life(out_life), .out_ready(out_ready),
    .cycle_count(cycle_count), .q_full(q_full), .q_empty(q_empty), .occupancy(occupancy));

  request_queue #(.ADDRESS_WIDTH(AW), .DEPTH(DEPTH), .LIFE_W(LIFE_W), .FAST_FWD(1)) dut_ff (
    .CPU_clock(CPU_clock), .rst_n(f_rst_n), .in_valid(f_in_valid), .in_time(f_in_time),
    .in_op(f_in_op), .in_addr(f_in_addr), .in_ready(f_in_ready), .out_valid(f_out_valid),
    .out_op(f_out_op), .out_addr(f_out_addr), .out_life(f_out_life), .out_ready(f_out_ready),
    .cycle_count(f_cc), .q_full(f_q_full), .q_empty(f_q_empty), .occupancy(f_occ));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the queue is a list of entries stamped with the edge number of their enqueue.
  typedef struct {
    logic [1:0]    op;
    logic [AW-1:0] addr;
    int            enq_step;
  } ent_t;

  ent_t          mq[$];
  logic [AW-1:0] dut_popped[$];
  int            m_step = 0;
  bit            m_known = 0;
  logic [31:0]   m_cc;
  bit            m_stg_vld, m_elig;
  logic [31:0]   m_stg_time;
  logic [1:0]    m_stg_op;
  logic [AW-1:0] m_stg_addr;

  function automatic int m_life();
    int d;
    d = m_step - mq[0].enq_step;
    return (d > LIFE_MAX) ? LIFE_MAX : d;
  endfunction

  task automatic model_compare();
    check("in_ready", in_ready, !m_stg_vld);
    check("out_valid", out_valid, mq.size() != 0);
    check("cycle_count", cycle_count, m_cc);
    check("occupancy", occupancy, mq.size());
    check("q_full", q_full, mq.size() == DEPTH);
    check("q_empty", q_empty, mq.size() == 0);
    if (mq.size() != 0) begin
      check("out_op", out_op, mq[0].op);
      check("out_addr", out_addr, mq[0].addr);
      check("out_life", out_life, m_life());
    end
  endtask

  task automatic model_step();
    bit   pop, full, enq, reached;
    ent_t e;
    if (!rst_n) begin
      mq.delete();
      m_cc      = '0;
      m_stg_vld = 0;
      m_elig    = 0;
      m_known   = 1;
    end else begin
      pop  = (mq.size() != 0) && out_ready;
      full = (mq.size() == DEPTH);
      enq  = 0;
      if (!m_stg_vld) begin
        if (in_valid && in_op != 2'd3) begin
          m_stg_vld  = 1;
          m_stg_time = in_time;
          m_stg_op   = in_op;
          m_stg_addr = in_addr;
          m_elig     = (in_time <= m_cc);
        end
      end else begin
        reached = (m_stg_time <= m_cc);
        if (m_elig ? (!full || pop) : (reached && !full)) enq = 1;
        else if (reached) m_elig = 1;
      end
      if (pop) void'(mq.pop_front());
      if (enq) begin
        e.op = m_stg_op; e.addr = m_stg_addr; e.enq_step = m_step + 1;
        mq.push_back(e);
        m_stg_vld = 0;
      end
      m_cc = m_cc + 32'd1;
    end
    m_step++;
  endtask

  task automatic cycle();
    if (m_known) model_compare();
    if (rst_n && out_valid && out_ready) dut_popped.push_back(out_addr);
    model_step();
    @(posedge CPU_clock);
    @(negedge CPU_clock);
  endtask

  task automatic fclk();
    @(posedge CPU_clock);
    @(negedge CPU_clock);
  endtask

  typedef struct {
    bit            iv;
    logic [31:0]   t;
    logic [1:0]    op;
    logic [AW-1:0] addr;
    bit            ordy;
    bit            e_rdy;
    bit            e_ov;
    logic [31:0]   e_cc;
    int            e_occ;
    logic [1:0]    e_op;
    logic [AW-1:0] e_addr;
    int            e_life;
  } vec_t;

  function automatic vec_t mk(bit iv, logic [31:0] t, logic [1:0] op, logic [AW-1:0] addr, bit ordy,
                              bit e_rdy, bit e_ov, logic [31:0] e_cc, int e_occ,
                              logic [1:0] e_op, logic [AW-1:0] e_addr, int e_life);
    vec_t v;
    v.iv = iv; v.t = t; v.op = op; v.addr = addr; v.ordy = ordy;
    v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_cc = e_cc; v.e_occ = e_occ;
    v.e_op = e_op; v.e_addr = e_addr; v.e_life = e_life;
    return v;
  endfunction

  vec_t          vt[14];
  int            sent, rp;
  logic [AW-1:0] base;

  initial begin
    vt[0]  = mk(1, 5,   0, 33'h1_0000_0040, 0,  1, 0, 0,  0, 0, 0, 0);
    vt[1]  = mk(0, 0,   0, 0,               0,  0, 0, 1,  0, 0, 0, 0);
    vt[2]  = mk(0, 0,   0, 0,               0,  0, 0, 2,  0, 0, 0, 0);
    vt[3]  = mk(0, 0,   0, 0,               0,  0, 0, 3,  0, 0, 0, 0);
    vt[4]  = mk(0, 0,   0, 0,               0,  0, 0, 4,  0, 0, 0, 0);
    vt[5]  = mk(0, 0,   0, 0,               0,  0, 0, 5,  0, 0, 0, 0);
    vt[6]  = mk(1, 100, 3, 33'h0_DEAD_BEEF, 0,  1, 1, 6,  1, 0, 33'h1_0000_0040, 0);
    vt[7]  = mk(0, 0,   0, 0,               1,  1, 1, 7,  1, 0, 33'h1_0000_0040, 1);
    vt[8]  = mk(1, 3,   1, 33'h0_0000_1234, 0,  1, 0, 8,  0, 0, 0, 0);
    vt[9]  = mk(0, 0,   0, 0,               0,  0, 0, 9,  0, 0, 0, 0);
    vt[10] = mk(1, 10,  2, 33'h1_FFFF_FFFF, 1,  1, 1, 10, 1, 1, 33'h0_0000_1234, 0);
    vt[11] = mk(0, 0,   0, 0,               0,  0, 0, 11, 0, 0, 0, 0);
    vt[12] = mk(0, 0,   0, 0,               1,  1, 1, 12, 1, 2, 33'h1_FFFF_FFFF, 0);
    vt[13] = mk(0, 0,   0, 0,               0,  1, 0, 13, 0, 0, 0, 0);

    rst_n = 0; in_valid = 0; in_time = 0; in_op = 0; in_addr = 0; out_ready = 0;
    f_rst_n = 0; f_in_valid = 0; f_in_time = 0; f_in_op = 0; f_in_addr = 0; f_out_ready = 0;

    // Fast-forward instance
    fclk();
    f_rst_n = 1;
    check("ff_reset_cc", f_cc, 0);
    check("ff_reset_in_ready", f_in_ready, 1);
    f_in_valid = 1; f_in_time = 5; f_in_op = 0; f_in_addr = 33'h1_0000_0040;
    fclk();
    f_in_valid = 0;
    check("ff_cc_after_accept", f_cc, 1);
    fclk();
    check("ff_jump_cc", f_cc, 5);
    check("ff_jump_out_valid", f_out_valid, 0);
    fclk();
    check("ff_enq_cc", f_cc, 6);
    check("ff_enq_out_valid", f_out_valid, 1);
    check("ff_enq_out_addr", f_out_addr, 33'h1_0000_0040);
    f_out_ready = 1; fclk(); f_out_ready = 0;
    f_in_valid = 1; f_in_op = 3; f_in_time = 100;
    fclk();
    f_in_valid = 0;
    check("ff_nop_in_ready", f_in_ready, 1);
    check("ff_nop_occ", f_occ, 0);
    check("ff_nop_cc", f_cc, 8);
    fclk();
    check("ff_nop_no_jump", f_cc, 9);
    f_in_valid = 1; f_in_op = 0; f_in_time = 0; fclk(); f_in_valid = 0; fclk();
    check("ff_hold_occ", f_occ, 1);
    f_in_valid = 1; f_in_time = 200; fclk(); f_in_valid = 0; fclk();
    check("ff_nonempty_no_jump", f_cc, 13);
    f_out_ready = 1; fclk(); f_out_ready = 0;
    check("ff_after_pop_cc", f_cc, 14);
    fclk();
    check("ff_jump_200", f_cc, 200);
    fclk();
    check("ff_late_enq_cc", f_cc, 201);
    check("ff_late_enq_valid", f_out_valid, 1);

    // Main instance: reset state
    cycle();
    rst_n = 1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_q_empty", q_empty, 1);
    check("rst_q_full", q_full, 0);
    check("rst_cc", cycle_count, 0);
    check("rst_occ", occupancy, 0);
    check("rst_out_op", out_op, 0);
    check("rst_out_addr", out_addr, 0);
    check("rst_out_life", out_life, 0);

    for (int i = 0; i < 14; i++) begin
      in_valid = vt[i].iv; in_time = vt[i].t; in_op = vt[i].op;
      in_addr = vt[i].addr; out_ready = vt[i].ordy;
      check($sformatf("tbl%0d_in_ready", i), in_ready, vt[i].e_rdy);
      check($sformatf("tbl%0d_out_valid", i), out_valid, vt[i].e_ov);
      check($sformatf("tbl%0d_cc", i), cycle_count, vt[i].e_cc);
      check($sformatf("tbl%0d_occ", i), occupancy, vt[i].e_occ);
      if (vt[i].e_ov) begin
        check($sformatf("tbl%0d_out_op", i), out_op, vt[i].e_op);
        check($sformatf("tbl%0d_out_addr", i), out_addr, vt[i].e_addr);
        check($sformatf("tbl%0d_out_life", i), out_life, vt[i].e_life);
      end
      cycle();
    end
    in_valid = 0; out_ready = 0;

    // Fill to DEPTH, 17th waits for space
    base = 33'h1_2000_0000;
    sent = 0;
    for (int c = 0; c < 200 && sent < 17; c++) begin
      in_valid = !m_stg_vld; in_time = 0; in_op = 2'(sent % 3);
      in_addr = base + AW'(sent * 64);
      if (in_valid) sent++;
      cycle();
    end
    in_valid = 0;
    check("fill_sent", sent, 17);
    cycle(); cycle();
    check("fill_q_full", q_full, 1);
    check("fill_occ", occupancy, 16);
    check("fill_in_ready", in_ready, 0);
    out_ready = 1; cycle(); out_ready = 0;
    check("fullpop_occ", occupancy, 16);
    check("fullpop_q_full", q_full, 1);
    check("fullpop_in_ready", in_ready, 1);
    check("fullpop_head", out_addr, base + AW'(64));
    out_ready = 1;
    for (int c = 0; c < 40 && mq.size() != 0; c++) cycle();
    out_ready = 0;
    check("fill_drained", occupancy, 0);

    // Age saturation, then the next entry shows its own age
    in_valid = 1; in_time = 0; in_op = 1; in_addr = 33'h0_0000_0AAA; cycle();
    in_valid = 0; cycle();
    repeat (200) cycle();
    in_valid = 1; in_addr = 33'h0_0000_0BBB; cycle();
    in_valid = 0; cycle();
    repeat (100) cycle();
    check("life_sat_addr", out_addr, 33'h0_0000_0AAA);
    check("life_sat", out_life, LIFE_MAX);
    out_ready = 1; cycle(); out_ready = 0;
    check("life_next_addr", out_addr, 33'h0_0000_0BBB);
    check("life_next", out_life, 101);
    out_ready = 1;
    for (int c = 0; c < 10 && mq.size() != 0; c++) cycle();
    out_ready = 0;

    // Reset with 5 queued and a request waiting for its time
    sent = 0;
    for (int c = 0; c < 100 && sent < 5; c++) begin
      in_valid = !m_stg_vld; in_time = m_cc; in_op = 0; in_addr = AW'(c + 1);
      if (in_valid) sent++;
      cycle();
    end
    in_valid = 0; cycle();
    in_valid = 1; in_time = m_cc + 32'd50; in_addr = 33'h0_0000_0777; cycle();
    in_valid = 0; cycle();
    check("prerst_occ", occupancy, 5);
    check("prerst_in_ready", in_ready, 0);
    rst_n = 0; cycle(); rst_n = 1;
    check("midrst_occ", occupancy, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_cc", cycle_count, 0);
    check("midrst_out_addr", out_addr, 0);
    check("midrst_out_op", out_op, 0);
    check("midrst_out_life", out_life, 0);

    // Stream 40 requests with the scheduler always ready
    dut_popped.delete();
    base = 33'h0_4000_0000;
    sent = 0;
    out_ready = 1;
    for (int c = 0; c < 400 && sent < 40; c++) begin
      in_valid = !m_stg_vld; in_time = m_cc; in_op = 2'(c % 3);
      in_addr = base + AW'(sent);
      if (in_valid) sent++;
      cycle();
    end
    in_valid = 0;
    for (int c = 0; c < 20 && (mq.size() != 0 || m_stg_vld); c++) cycle();
    check("wrap_count", dut_popped.size(), 40);
    for (int i = 0; i < 40 && i < dut_popped.size(); i++)
      check($sformatf("wrap_addr%0d", i), dut_popped[i], base + AW'(i));
    out_ready = 0;

    // Randomized run, including past/non-monotonic times and occasional resets
    for (int c = 0; c < 3000; c++) begin
      rp = (c < 1000) ? 15 : (c < 2000) ? 90 : 50;
      rst_n     = ($urandom_range(0, 499) != 0);
      in_valid  = ($urandom_range(0, 99) < 60);
      in_op     = 2'($urandom_range(0, 3));
      in_time   = (m_cc < 32'd4) ? m_cc : m_cc + 32'($urandom_range(0, 12)) - 32'd4;
      in_addr   = AW'({$urandom, $urandom});
      out_ready = ($urandom_range(0, 99) < rp);
      cycle();
    end
    rst_n = 1; in_valid = 0; out_ready = 0;
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
